// File: rtl/misc_v_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : misc_v_pkg
//  Description : Shared widths, ALU op codes, write-back select codes, the
//                EX/MEM register layout and the operand forwarding helper
//                for the 16-bit MISC-V core.
//  Revision    : 1.0  initial release
// ============================================================================
package misc_v_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  // Write-back source select codes
  localparam logic [1:0] RS_ALU = 2'd0;
  localparam logic [1:0] RS_MEM = 2'd1;
  localparam logic [1:0] RS_PC2 = 2'd2;
  localparam logic [1:0] RS_IMM = 2'd3;

  // Contents of the EX/MEM pipeline register; all-zero is a bubble
  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              mem_read;
    logic [1:0]        reg_store;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] pcp2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rd;
  } ex_mem_t;

  // Operand forwarding: r0 is never forwarded, EX/MEM beats write-back,
  // and ex_ok is low when the EX/MEM entry is a load (value not yet known).
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_W-1:0]  r,
    input logic [DATA_W-1:0] v,
    input logic              ex_we,
    input logic [REG_W-1:0]  ex_rd,
    input logic              ex_ok,
    input logic [DATA_W-1:0] ex_val,
    input logic              wb_we,
    input logic [REG_W-1:0]  wb_rd,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] res;
    res = v;
    if (r != '0) begin
      if (ex_we && (ex_rd == r) && ex_ok) begin
        res = ex_val;
      end else if (wb_we && (wb_rd == r)) begin
        res = wb_data;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage_if
//  Description : ID/EX inputs, write-back forwarding inputs, pipeline control
//                and EX/MEM register outputs of the execute stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_mem_stage_if;
  import misc_v_pkg::*;

  // ID/EX bundle
  logic              IRegWrite;
  logic              IALUSrc;
  logic              IMemWrite;
  logic              IMemRead;
  logic [2:0]        IALUOP;
  logic [1:0]        IRegStore;
  logic [DATA_W-1:0] IPCP2;
  logic [DATA_W-1:0] I1stArg;
  logic [DATA_W-1:0] I2ndArg;
  logic [DATA_W-1:0] I3rdArg;
  logic [DATA_W-1:0] IImm;
  logic [REG_W-1:0]  IRs1;
  logic [REG_W-1:0]  IRs2;
  logic [REG_W-1:0]  IRd;

  // Write-back stage
  logic              WBRegWrite;
  logic [REG_W-1:0]  WBRd;
  logic [DATA_W-1:0] WBData;

  // Pipeline control
  logic              Stall;
  logic              Flush;

  // EX/MEM register
  logic              ORegWrite;
  logic              OMemWrite;
  logic              OMemRead;
  logic [1:0]        ORegStore;
  logic [DATA_W-1:0] OALUResult;
  logic [DATA_W-1:0] OStoreData;
  logic [DATA_W-1:0] OPCP2;
  logic [DATA_W-1:0] OImm;
  logic [REG_W-1:0]  ORd;

  modport master (
    output IRegWrite, IALUSrc, IMemWrite, IMemRead, IALUOP, IRegStore,
           IPCP2, I1stArg, I2ndArg, I3rdArg, IImm, IRs1, IRs2, IRd,
           WBRegWrite, WBRd, WBData, Stall, Flush,
    input  ORegWrite, OMemWrite, OMemRead, ORegStore,
           OALUResult, OStoreData, OPCP2, OImm, ORd
  );

  modport slave (
    input  IRegWrite, IALUSrc, IMemWrite, IMemRead, IALUOP, IRegStore,
           IPCP2, I1stArg, I2ndArg, I3rdArg, IImm, IRs1, IRs2, IRd,
           WBRegWrite, WBRd, WBData, Stall, Flush,
    output ORegWrite, OMemWrite, OMemRead, ORegStore,
           OALUResult, OStoreData, OPCP2, OImm, ORd
  );

endinterface
`default_nettype wire

// File: rtl/alu16.sv
`default_nettype none
// ============================================================================
//  Module      : alu16
//  Description : Combinational 16-bit ALU. Wrapping arithmetic, 4-bit shift
//                amount, signed set-less-than.
//  Revision    : 1.0  initial release
// ============================================================================
module alu16
  import misc_v_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
);

  // Select the operation; only the low four bits of b shift
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[3:0];
      ALU_SRL: result = a >> b[3:0];
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage
//  Description : Execute stage with RAW forwarding from EX/MEM and write-back,
//                followed by the EX/MEM pipeline register with stall/flush.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_mem_stage
  import misc_v_pkg::*;
(
  input  logic         CLK,
  input  logic         Reset,
  ex_mem_stage_if.slave bus
);

  ex_mem_t           ex_mem_q;
  ex_mem_t           ex_mem_d;
  logic [DATA_W-1:0] ex_val;
  logic              ex_ok;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] alu_result;

  // Value the EX/MEM entry will write back, when it is already known
  always_comb begin
    ex_ok  = (ex_mem_q.reg_store != RS_MEM);
    ex_val = ex_mem_q.alu_result;
    case (ex_mem_q.reg_store)
      RS_PC2:  ex_val = ex_mem_q.pcp2;
      RS_IMM:  ex_val = ex_mem_q.imm;
      default: ex_val = ex_mem_q.alu_result;
    endcase
  end

  // Forwarded operands and store data
  always_comb begin
    op_a = fwd(bus.IRs1, bus.I1stArg, ex_mem_q.reg_write, ex_mem_q.rd, ex_ok,
               ex_val, bus.WBRegWrite, bus.WBRd, bus.WBData);
    op_b = bus.IALUSrc ? bus.IImm :
           fwd(bus.IRs2, bus.I2ndArg, ex_mem_q.reg_write, ex_mem_q.rd, ex_ok,
               ex_val, bus.WBRegWrite, bus.WBRd, bus.WBData);
    store_data = fwd(bus.IRd, bus.I3rdArg, ex_mem_q.reg_write, ex_mem_q.rd,
                     ex_ok, ex_val, bus.WBRegWrite, bus.WBRd, bus.WBData);
  end

  alu16 u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (bus.IALUOP),
    .result (alu_result)
  );

  // Next EX/MEM contents from the current instruction
  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = bus.IRegWrite;
    ex_mem_d.mem_write  = bus.IMemWrite;
    ex_mem_d.mem_read   = bus.IMemRead;
    ex_mem_d.reg_store  = bus.IRegStore;
    ex_mem_d.alu_result = alu_result;
    ex_mem_d.store_data = store_data;
    ex_mem_d.pcp2       = bus.IPCP2;
    ex_mem_d.imm        = bus.IImm;
    ex_mem_d.rd         = bus.IRd;
  end

  // Pipeline register: reset, then flush (bubble), then stall (hold)
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      ex_mem_q <= '0;
    end else if (bus.Flush) begin
      ex_mem_q <= '0;
    end else if (!bus.Stall) begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign bus.ORegWrite  = ex_mem_q.reg_write;
  assign bus.OMemWrite  = ex_mem_q.mem_write;
  assign bus.OMemRead   = ex_mem_q.mem_read;
  assign bus.ORegStore  = ex_mem_q.reg_store;
  assign bus.OALUResult = ex_mem_q.alu_result;
  assign bus.OStoreData = ex_mem_q.store_data;
  assign bus.OPCP2      = ex_mem_q.pcp2;
  assign bus.OImm       = ex_mem_q.imm;
  assign bus.ORd        = ex_mem_q.rd;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_stage
//  Description : Scoreboard bench for ex_mem_stage with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

  logic CLK = 1'b0;
  logic Reset;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Expected register image: rw,mw,mr,rs,alu,sd,pc2,imm,rd
  logic [71:0] exp_q[$];
  string       name_q[$];
  logic [71:0] last_exp;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [71:0] mk(
    input logic rw, input logic mw, input logic mr, input logic [1:0] rs,
    input logic [15:0] alu, input logic [15:0] sd, input logic [15:0] pc,
    input logic [15:0] imm, input logic [2:0] rd);
    return {rw, mw, mr, rs, alu, sd, pc, imm, rd};
  endfunction

  // Drive a neutral instruction
  task automatic clear_in();
    Reset = 1'b1;
    bus.IRegWrite = 0; bus.IALUSrc = 0; bus.IMemWrite = 0; bus.IMemRead = 0;
    bus.IALUOP = 0; bus.IRegStore = 0; bus.IPCP2 = 0; bus.I1stArg = 0;
    bus.I2ndArg = 0; bus.I3rdArg = 0; bus.IImm = 0; bus.IRs1 = 0;
    bus.IRs2 = 0; bus.IRd = 0; bus.WBRegWrite = 0; bus.WBRd = 0;
    bus.WBData = 0; bus.Stall = 0; bus.Flush = 0;
  endtask

  // Push the expected post-edge image, then move to the next falling edge
  task automatic issue(input string nm, input logic [71:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    last_exp = e;
    @(negedge CLK);
  endtask

  task automatic alu_vec(input string nm, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r);
    clear_in();
    bus.IALUOP = op; bus.I1stArg = a; bus.I2ndArg = b;
    issue(nm, mk(0, 0, 0, 0, r, 0, 0, 0, 0));
  endtask

  // Monitor: compare the register image just after every rising edge
  initial begin
    logic [71:0] act;
    logic [71:0] e;
    string       nm;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {bus.ORegWrite, bus.OMemWrite, bus.OMemRead, bus.ORegStore,
               bus.OALUResult, bus.OStoreData, bus.OPCP2, bus.OImm, bus.ORd};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  // Stimulus
  initial begin
    clear_in();
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      Reset = 1'b0;
      bus.IRegWrite = 1'($urandom); bus.IMemWrite = 1'($urandom);
      bus.IALUOP = 3'($urandom); bus.I1stArg = 16'($urandom);
      bus.I2ndArg = 16'($urandom); bus.IImm = 16'($urandom);
      bus.IPCP2 = 16'($urandom); bus.IRd = 3'($urandom);
      bus.IRegStore = 2'($urandom); bus.Stall = 1'($urandom);
      issue("reset", '0);
    end
    clear_in();
    bus.I1stArg = 3; bus.I2ndArg = 4; bus.IRegWrite = 1; bus.IRd = 2;
    issue("first_load", mk(1, 0, 0, 0, 16'd7, 0, 0, 0, 2));

    // EX/MEM forwarding
    clear_in();
    bus.I1stArg = 5; bus.I2ndArg = 6; bus.IRd = 2; bus.IRegWrite = 1;
    issue("add_r2_sd_fwd", mk(1, 0, 0, 0, 16'd11, 16'd7, 0, 0, 2));
    clear_in();
    bus.IALUOP = 1; bus.IRs1 = 2; bus.I2ndArg = 1; bus.IRd = 5; bus.IRegWrite = 1;
    issue("sub_exmem_fwd", mk(1, 0, 0, 0, 16'd10, 0, 0, 0, 5));
    clear_in();
    bus.I1stArg = 5; bus.I2ndArg = 6; bus.IRd = 2; bus.IRegWrite = 1;
    issue("add_r2_again", mk(1, 0, 0, 0, 16'd11, 0, 0, 0, 2));
    clear_in();
    bus.IALUOP = 1; bus.I2ndArg = 1; bus.IRd = 5; bus.IRegWrite = 1;
    issue("sub_r0_nofwd", mk(1, 0, 0, 0, 16'hFFFF, 0, 0, 0, 5));

    // Priority EX/MEM over WB, then load in EX/MEM defers to WB
    clear_in();
    bus.I1stArg = 9; bus.IRd = 3; bus.IRegWrite = 1;
    issue("add_r3_9", mk(1, 0, 0, 0, 16'd9, 0, 0, 0, 3));
    clear_in();
    bus.WBRegWrite = 1; bus.WBRd = 3; bus.WBData = 1;
    bus.IALUOP = 2; bus.IRs1 = 3; bus.IALUSrc = 1; bus.IImm = 16'h000F;
    bus.IRd = 6; bus.IRegWrite = 1;
    issue("and_exmem_prio", mk(1, 0, 0, 0, 16'd9, 0, 0, 16'h000F, 6));
    clear_in();
    bus.WBRegWrite = 1; bus.WBRd = 3; bus.WBData = 1;
    bus.IRegStore = 1; bus.IMemRead = 1; bus.IRd = 3; bus.IRegWrite = 1;
    issue("load_r3_sd_wb", mk(1, 0, 1, 1, 0, 16'd1, 0, 0, 3));
    clear_in();
    bus.WBRegWrite = 1; bus.WBRd = 3; bus.WBData = 1;
    bus.IALUOP = 2; bus.IRs1 = 3; bus.IALUSrc = 1; bus.IImm = 16'h000F;
    bus.IRd = 6; bus.IRegWrite = 1;
    issue("and_load_no_fwd", mk(1, 0, 0, 0, 16'd1, 0, 0, 16'h000F, 6));

    // Store data from WB
    clear_in();
    bus.IMemWrite = 1; bus.IRd = 4; bus.WBRd = 4; bus.WBData = 16'hBEEF;
    bus.WBRegWrite = 1; bus.I1stArg = 16'h0010; bus.IALUSrc = 1;
    bus.IImm = 16'h0002; bus.IPCP2 = 16'h0040;
    issue("store_wb_fwd", mk(0, 1, 0, 0, 16'h0012, 16'hBEEF, 16'h0040, 16'h0002, 4));

    // Stall holds for 3 cycles with changing inputs
    for (int i = 0; i < 3; i++) begin
      clear_in();
      bus.Stall = 1; bus.IRegWrite = 1; bus.I1stArg = 16'(100 + i);
      bus.IRd = 3'(i + 1); bus.IPCP2 = 16'(i);
      issue("stall_hold", last_exp);
    end
    clear_in();
    bus.Stall = 1; bus.Flush = 1; bus.IRegWrite = 1; bus.I1stArg = 7; bus.IRd = 7;
    issue("stall_flush", '0);

    // PC+2 forwarding from EX/MEM
    clear_in();
    bus.IRegStore = 2; bus.IPCP2 = 16'h0100; bus.IRd = 1; bus.IRegWrite = 1;
    issue("pc2_wb_sel", mk(1, 0, 0, 2, 0, 0, 16'h0100, 0, 1));
    clear_in();
    bus.IRs1 = 1; bus.I2ndArg = 5; bus.IRd = 2; bus.IRegWrite = 1;
    issue("pc2_fwd", mk(1, 0, 0, 0, 16'h0105, 0, 0, 0, 2));

    // ALU corners
    alu_vec("slt_signed", 3'd7, 16'h8000, 16'h0001, 16'h0001);
    alu_vec("sll_amt4",   3'd5, 16'h0001, 16'h0011, 16'h0002);
    alu_vec("srl_15",     3'd6, 16'h8000, 16'h000F, 16'h0001);
    alu_vec("add_wrap",   3'd0, 16'hFFFF, 16'h0001, 16'h0000);
    alu_vec("xor",        3'd4, 16'h00FF, 16'h0F0F, 16'h0FF0);
    alu_vec("or",         3'd3, 16'h00F0, 16'h0F00, 16'h0FF0);

    // Reset during stall clears, then the next edge loads
    clear_in();
    bus.IRegWrite = 1; bus.I1stArg = 2; bus.I2ndArg = 2; bus.IRd = 7;
    issue("pre_reset_load", mk(1, 0, 0, 0, 16'd4, 0, 0, 0, 7));
    clear_in();
    Reset = 0; bus.Stall = 1;
    issue("reset_mid_stall", '0);
    clear_in();
    bus.I1stArg = 1; bus.I2ndArg = 1; bus.IRd = 1; bus.IRegWrite = 1;
    issue("load_after_reset", mk(1, 0, 0, 0, 16'd2, 0, 0, 0, 1));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
